// File: rtl/dcache_ctrl.sv
// dcache_ctrl: sequencing FSM between the CPU load/store port, a direct-mapped
// 4-word-line data cache and the backing data memory.
//   - Read hit: no stall.
//   - Read miss: one line refill from data memory.
//   - Store: write-through, no-write-allocate.
//
// Optional feature macro: DCACHE_PERF_CNT_EN
//   When defined, the hit/miss/store counters are built and saturate at all-ones.
//   When undefined, the counter logic is not built and the counter outputs read 0.
//
// Ports
//   clk_i           system clock, rising edge
//   rst_ni          asynchronous reset, active-low
//   cpu_rd_i        CPU load request, level, held while stall_o=1
//   cpu_wr_i        CPU store request, level, held while stall_o=1
//   cpu_addr_i      CPU word address
//   cache_hit_i     tag match and valid for cpu_addr_i (combinational, from tag array)
//   mem_ready_i     data-memory completion pulse
//   stall_o         freeze CPU pipeline (combinational)
//   mem_rd_en_o     data-memory line read enable (registered)
//   mem_wr_en_o     data-memory word write enable (registered)
//   mem_miss_o      data-memory miss strobe, first read cycle only (registered)
//   mem_addr_o      latched transaction address to data memory (registered)
//   refill_we_o     1-cycle strobe: cache writes line, tag, valid=1 (registered)
//   cache_wr_upd_o  store-hit word update strobe to cache data array (combinational)
//   hit_cnt_o       read-hit count
//   miss_cnt_o      read-miss count
//   wr_cnt_o        store count
module dcache_ctrl #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cpu_rd_i,
  input  logic              cpu_wr_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic              cache_hit_i,
  input  logic              mem_ready_i,
  output logic              stall_o,
  output logic              mem_rd_en_o,
  output logic              mem_wr_en_o,
  output logic              mem_miss_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              refill_we_o,
  output logic              cache_wr_upd_o,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o,
  output logic [CNT_W-1:0]  wr_cnt_o
);

  typedef enum logic [1:0] {
    StIdle,
    StRdMiss,
    StRefill,
    StWrThru
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              rd_en_q, wr_en_q, miss_q, refill_q;
  logic              idle_rd_hit;
  logic              cache_wr_upd;

  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    cache_wr_upd = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A store wins over a simultaneous load; the load is retried later.
        if (cpu_wr_i) begin
          state_d      = StWrThru;
          mem_addr_d   = cpu_addr_i;
          cache_wr_upd = cache_hit_i;
        end else if (cpu_rd_i && !cache_hit_i) begin
          state_d    = StRdMiss;
          mem_addr_d = cpu_addr_i;
        end
      end
      StRdMiss: begin
        if (mem_ready_i) state_d = StRefill;
      end
      StRefill: begin
        state_d = StIdle;
      end
      StWrThru: begin
        if (mem_ready_i) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Enables are decoded from the next state, so each is high exactly while the FSM is in
  // the matching state, and both drop for at least one cycle between transactions.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      mem_addr_q <= '0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      miss_q     <= 1'b0;
      refill_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      rd_en_q    <= (state_d == StRdMiss);
      wr_en_q    <= (state_d == StWrThru);
      miss_q     <= (state_q == StIdle) && (state_d == StRdMiss);
      refill_q   <= (state_d == StRefill);
    end
  end

  // Combinational outputs are masked during reset, when the FSM is forced to idle but the
  // CPU inputs may still be active.
  always_comb begin
    stall_o        = rst_ni && ((state_q != StIdle) ||
                                cpu_wr_i || (cpu_rd_i && !cache_hit_i));
    cache_wr_upd_o = rst_ni && cache_wr_upd;
  end

  assign mem_rd_en_o = rd_en_q;
  assign mem_wr_en_o = wr_en_q;
  assign mem_miss_o  = miss_q;
  assign mem_addr_o  = mem_addr_q;
  assign refill_we_o = refill_q;

  assign idle_rd_hit = (state_q == StIdle) && cpu_rd_i && cache_hit_i && !cpu_wr_i;

`ifdef DCACHE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic             miss_inc, wr_inc;

  always_comb begin
    miss_inc   = (state_q == StIdle) && (state_d == StRdMiss);
    wr_inc     = (state_q == StIdle) && (state_d == StWrThru);
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    if (idle_rd_hit && (hit_cnt_q != CntMax)) hit_cnt_d = hit_cnt_q + CntOne;
    if (miss_inc && (miss_cnt_q != CntMax))   miss_cnt_d = miss_cnt_q + CntOne;
    if (wr_inc && (wr_cnt_q != CntMax))       wr_cnt_d = wr_cnt_q + CntOne;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wr_cnt_q   <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
  assign wr_cnt_o   = wr_cnt_q;
`else
  logic unused_idle_rd_hit;
  assign unused_idle_rd_hit = idle_rd_hit;

  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
  assign wr_cnt_o   = '0;
`endif

endmodule
